// File: rtl/grid_scan.sv
// rtl/grid_scan.sv - candidate-point grid sweep with per-circle range evaluation and centroid accumulation
module grid_scan #(
    parameter int N = 8,
    parameter int K = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic signed [N+1:0]     x_lo,
    input  logic signed [N+1:0]     x_hi,
    input  logic signed [N+1:0]     y_lo,
    input  logic signed [N+1:0]     y_hi,
    input  logic [K*N-1:0]          xJ_all,
    input  logic [K*N-1:0]          yJ_all,
    input  logic [K*(N+1)-1:0]      rJ_all,
    output logic signed [N+1:0]     xP,
    output logic signed [N+1:0]     yP,
    output logic signed [N-1:0]     xJ,
    output logic signed [N-1:0]     yJ,
    output logic signed [N:0]       rJ,
    input  logic                    in_range,
    output logic                    busy,
    output logic                    done,
    output logic [2*N+4:0]          count,
    output logic signed [3*N+5:0]   sum_x,
    output logic signed [3*N+5:0]   sum_y,
    output logic                    found
);

    localparam int KW = (K > 1) ? $clog2(K) : 1;
    localparam logic [KW-1:0] KLAST = KW'(K - 1);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t                 state;
    logic [KW-1:0]          k;
    logic signed [N+1:0]    xl_q, xh_q, yl_q, yh_q;
    logic [K*N-1:0]         xj_q, yj_q;
    logic [K*(N+1)-1:0]     rj_q;

    logic                   last_pt;
    logic                   accept;
    logic [3*N+5:0]         xp_ext, yp_ext;

    always_comb begin
        last_pt = (xP == xh_q) && (yP == yh_q);
        accept  = in_range && (k == KLAST);
        xp_ext  = {{(2*N+4){xP[N+1]}}, xP};
        yp_ext  = {{(2*N+4){yP[N+1]}}, yP};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            k     <= '0;
            xl_q  <= '0;
            xh_q  <= '0;
            yl_q  <= '0;
            yh_q  <= '0;
            xj_q  <= '0;
            yj_q  <= '0;
            rj_q  <= '0;
            xP    <= '0;
            yP    <= '0;
            xJ    <= '0;
            yJ    <= '0;
            rJ    <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            count <= '0;
            sum_x <= '0;
            sum_y <= '0;
            found <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        xl_q  <= x_lo;
                        xh_q  <= x_hi;
                        yl_q  <= y_lo;
                        yh_q  <= y_hi;
                        xj_q  <= xJ_all;
                        yj_q  <= yJ_all;
                        rj_q  <= rJ_all;
                        xP    <= x_lo;
                        yP    <= y_lo;
                        k     <= '0;
                        xJ    <= xJ_all[N-1:0];
                        yJ    <= yJ_all[N-1:0];
                        rJ    <= rJ_all[N:0];
                        count <= '0;
                        sum_x <= '0;
                        sum_y <= '0;
                        found <= 1'b0;
                        if ((x_lo > x_hi) || (y_lo > y_hi)) begin
                            state <= DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            state <= SCAN;
                            busy  <= 1'b1;
                        end
                    end
                end
                SCAN: begin
                    if (in_range && (k != KLAST)) begin
                        // point still alive: present the next circle
                        k  <= k + KW'(1);
                        xJ <= xj_q[(int'(k) + 1)*N +: N];
                        yJ <= yj_q[(int'(k) + 1)*N +: N];
                        rJ <= rj_q[(int'(k) + 1)*(N+1) +: (N+1)];
                    end else begin
                        k  <= '0;
                        xJ <= xj_q[N-1:0];
                        yJ <= yj_q[N-1:0];
                        rJ <= rj_q[N:0];
                        if (accept) begin
                            count <= count + (2*N+5)'(1);
                            sum_x <= sum_x + xp_ext;
                            sum_y <= sum_y + yp_ext;
                        end
                        if (last_pt) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            found <= accept || (count != '0);
                        end else if (xP != xh_q) begin
                            xP <= xP + (N+2)'(1);
                        end else begin
                            // equality-based wrap keeps the counters inside the bounds
                            xP <= xl_q;
                            yP <= yP + (N+2)'(1);
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_grid_scan.sv
// tb/tb_grid_scan.sv - table-driven and randomized checks of grid_scan against a grid-sweep model
module tb_grid_scan;
    localparam int N = 8;
    localparam int K = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic signed [N+1:0] x_lo = '0, x_hi = '0, y_lo = '0, y_hi = '0;
    logic [K*N-1:0] xJ_all = '0, yJ_all = '0;
    logic [K*(N+1)-1:0] rJ_all = '0;
    logic signed [N+1:0] xP, yP;
    logic signed [N-1:0] xJ, yJ;
    logic signed [N:0] rJ;
    logic in_range;
    logic busy, done, found;
    logic [2*N+4:0] count;
    logic signed [3*N+5:0] sum_x, sum_y;

    int passes = 0;
    int checks = 0;
    int dx, dy, rr;

    always #5 clk = ~clk;

    grid_scan #(.N(N), .K(K)) dut (
        .clk(clk), .rst(rst), .start(start),
        .x_lo(x_lo), .x_hi(x_hi), .y_lo(y_lo), .y_hi(y_hi),
        .xJ_all(xJ_all), .yJ_all(yJ_all), .rJ_all(rJ_all),
        .xP(xP), .yP(yP), .xJ(xJ), .yJ(yJ), .rJ(rJ),
        .in_range(in_range), .busy(busy), .done(done),
        .count(count), .sum_x(sum_x), .sum_y(sum_y), .found(found)
    );

    // inclusive circle test standing in for the inside_ block
    always_comb begin
        dx = int'(xP) - int'(xJ);
        dy = int'(yP) - int'(yJ);
        rr = int'(rJ);
        in_range = (dx*dx + dy*dy) <= rr*rr;
    end

    typedef struct {
        int xl, xh, yl, yh;
        logic [23:0] xjb, yjb;
        logic [26:0] rjb;
        int ecnt, esx, esy, eev;
    } vec_t;

    vec_t vecs [7];

    function automatic logic [23:0] p3(int a, int b, int c);
        return {c[7:0], b[7:0], a[7:0]};
    endfunction

    function automatic logic [26:0] p3r(int a, int b, int c);
        return {c[8:0], b[8:0], a[8:0]};
    endfunction

    function automatic vec_t mkv(int xl, int xh, int yl, int yh, logic [23:0] xb, logic [23:0] yb,
                                 logic [26:0] rb, int c, int sx, int sy, int ev);
        vec_t v;
        v.xl = xl; v.xh = xh; v.yl = yl; v.yh = yh;
        v.xjb = xb; v.yjb = yb; v.rjb = rb;
        v.ecnt = c; v.esx = sx; v.esy = sy; v.eev = ev;
        return v;
    endfunction

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    // sweep every grid point, count circles evaluated up to the first miss
    task automatic model(input vec_t v, output int cnt, output int sx, output int sy, output int ev);
        cnt = 0; sx = 0; sy = 0; ev = 0;
        for (int y = v.yl; y <= v.yh; y++) begin
            for (int x = v.xl; x <= v.xh; x++) begin
                int kk;
                bit ok;
                ok = 1'b1;
                for (kk = 0; kk < K; kk++) begin
                    int cx, cy, r;
                    cx = int'($signed(v.xjb[kk*8 +: 8]));
                    cy = int'($signed(v.yjb[kk*8 +: 8]));
                    r  = int'($signed(v.rjb[kk*9 +: 9]));
                    if ((x-cx)*(x-cx) + (y-cy)*(y-cy) > r*r) begin
                        ok = 1'b0;
                        break;
                    end
                end
                if (ok) begin
                    ev += K; cnt++; sx += x; sy += y;
                end else begin
                    ev += kk + 1;
                end
            end
        end
    endtask

    task automatic run_and_check(input string nm, input vec_t v, input int mode,
                                 input int ecnt, input int esx, input int esy, input int eev);
        int lat;
        int c_cnt, c_sx, c_sy, c_fnd;
        @(posedge clk); #1;
        x_lo = (N+2)'(v.xl); x_hi = (N+2)'(v.xh);
        y_lo = (N+2)'(v.yl); y_hi = (N+2)'(v.yh);
        xJ_all = v.xjb; yJ_all = v.yjb; rJ_all = v.rjb;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        while (!done && lat < 3000) begin
            if (mode == 1 && lat == 5) begin
                start = 1'b1; x_lo = -10'sd100; x_hi = 10'sd100;
            end
            if (mode == 1 && lat == 6) start = 1'b0;
            if (mode == 2 && lat == 5) begin
                x_lo = -10'sd50; x_hi = 10'sd50; y_hi = 10'sd40;
                xJ_all = ~xJ_all; rJ_all = '0;
            end
            @(posedge clk); #1;
            lat++;
        end
        chk({nm, "_timeout"}, longint'(done), 1);
        c_cnt = int'(count); c_sx = int'(sum_x); c_sy = int'(sum_y); c_fnd = int'(found);
        chk({nm, "_count"}, c_cnt, ecnt);
        chk({nm, "_sum_x"}, c_sx, esx);
        chk({nm, "_sum_y"}, c_sy, esy);
        chk({nm, "_found"}, c_fnd, (ecnt != 0) ? 1 : 0);
        chk({nm, "_latency"}, lat, eev);
        chk({nm, "_busy_at_done"}, longint'(busy), 0);
        @(posedge clk); #1;
        chk({nm, "_done_pulse"}, longint'(done), 0);
        chk({nm, "_hold"}, (int'(count) == c_cnt && int'(found) == c_fnd && int'(sum_x) == c_sx) ? 1 : 0, 1);
    endtask

    initial begin
        int mc, msx, msy, mev;
        int seen_done;
        vec_t rv;

        vecs[0] = mkv(-2, 2, -2, 2, p3(0,0,0), p3(0,0,0), p3r(1,1,1), 5, 0, 0, 35);
        vecs[1] = mkv(0, 3, 0, 1, p3(0,0,0), p3(0,0,0), p3r(100,100,100), 8, 12, 4, 24);
        vecs[2] = mkv(-10, 10, -10, 10, p3(-50,50,0), p3(0,0,0), p3r(5,5,5), 0, 0, 0, 441);
        vecs[3] = mkv(10, 10, 10, 10, p3(10,10,10), p3(10,10,10), p3r(0,0,0), 1, 10, 10, 3);
        vecs[4] = mkv(3, 2, 0, 0, p3(0,0,0), p3(0,0,0), p3r(9,9,9), 0, 0, 0, 0);
        vecs[5] = mkv(-3, -1, -2, -2, p3(-2,-2,-2), p3(-2,-2,-2), p3r(1,1,1), 3, -6, -6, 9);
        vecs[6] = mkv(509, 511, 511, 511, p3(127,127,127), p3(127,127,127), p3r(255,255,255), 0, 0, 0, 3);

        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", longint'(busy), 0);
        chk("reset_done", longint'(done), 0);
        chk("reset_count", longint'(count), 0);
        chk("reset_sum_x", longint'(sum_x), 0);
        chk("reset_xP", longint'(xP), 0);
        chk("reset_rJ", longint'(rJ), 0);
        rst = 1'b0;

        for (int i = 0; i < 7; i++)
            run_and_check($sformatf("vec%0d", i), vecs[i], 0,
                          vecs[i].ecnt, vecs[i].esx, vecs[i].esy, vecs[i].eev);

        run_and_check("restart_ignored", vecs[0], 1, 5, 0, 0, 35);
        run_and_check("inputs_change_busy", vecs[1], 2, 8, 12, 4, 24);

        // reset asserted in the middle of a scan
        @(posedge clk); #1;
        x_lo = -10'sd2; x_hi = 10'sd2; y_lo = -10'sd2; y_hi = 10'sd2;
        xJ_all = '0; yJ_all = '0; rJ_all = p3r(1,1,1);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        seen_done = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (done) seen_done = 1;
        end
        chk("midrst_busy_before", longint'(busy), 1);
        #2 rst = 1'b1;
        #1;
        chk("midrst_busy", longint'(busy), 0);
        chk("midrst_count", longint'(count), 0);
        chk("midrst_sums", (sum_x == 0 && sum_y == 0) ? 1 : 0, 1);
        chk("midrst_xP", longint'(xP), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done || busy) seen_done = 1;
        end
        chk("midrst_no_done", seen_done, 0);
        run_and_check("after_rst", vecs[1], 0, 8, 12, 4, 24);

        for (int t = 0; t < 25; t++) begin
            rv.xl = int'($urandom_range(40)) - 20;
            rv.xh = rv.xl + int'($urandom_range(7)) - 1;
            rv.yl = int'($urandom_range(40)) - 20;
            rv.yh = rv.yl + int'($urandom_range(7)) - 1;
            rv.xjb = p3(int'($urandom_range(40)) - 20, int'($urandom_range(40)) - 20, int'($urandom_range(40)) - 20);
            rv.yjb = p3(int'($urandom_range(40)) - 20, int'($urandom_range(40)) - 20, int'($urandom_range(40)) - 20);
            rv.rjb = p3r(int'($urandom_range(25)) + 5, int'($urandom_range(25)) + 5, int'($urandom_range(25)) + 5);
            model(rv, mc, msx, msy, mev);
            run_and_check($sformatf("rand%0d", t), rv, 0, mc, msx, msy, mev);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/grid_scan.md
# grid_scan

Sequential candidate-point generator and result accumulator for the jammer-localisation datapath. It sweeps a rectangular grid of candidate points P and, for each point, presents the K latched jammer circles one per cycle to the combinational `inside_` range check. It consumes that check's `in_range` result and accumulates the count and the coordinate sums of points lying inside all K circles; downstream logic divides the sums by the count to form the centroid estimate.

## Interface
- `N`, 8: coordinate width; jammer coordinates are N bits, point coordinates N+2 bits, radius N+1 bits (all signed).
- `K`, 3: number of jammer circles, K ≥ 1.
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `start` in 1: one-cycle scan request; ignored while `busy`.
- `x_lo`, `x_hi`, `y_lo`, `y_hi` in N+2 signed: inclusive grid bounds, latched on accepted `start`.
- `xJ_all`, `yJ_all` in K*N: packed jammer centres, slice k = bits [k*N +: N], latched on `start`.
- `rJ_all` in K*(N+1): packed radii, latched on `start`.
- `xP`, `yP` out N+2 signed: current candidate point, registered, to `inside_`.
- `xJ`, `yJ` out N, `rJ` out N+1: current jammer circle k, registered, to `inside_`.
- `in_range` in 1: `inside_` result for the current outputs (inclusive: dx²+dy² ≤ r²).
- `busy` out 1: scan in progress.
- `done` out 1: one-cycle pulse at scan end.
- `count` out 2N+5 unsigned: number of points inside all circles.
- `sum_x`, `sum_y` out 3N+6 signed: sums of the xP / yP values of those points.
- `found` out 1: `count` ≠ 0, valid while `done` is high and held afterwards.

## Operation
- States: IDLE, SCAN, DONE.
- IDLE, accepted `start`:
  - latch bounds and jammers; clear `count`, `sum_x`, `sum_y`, `found`; set xP=x_lo, yP=y_lo, k=0.
  - if x_lo > x_hi or y_lo > y_hi, go to DONE (empty grid); else go to SCAN.
- SCAN, once per cycle, evaluate (P, k) by sampling `in_range`:
  - `in_range`=0: reject P, advance point, k=0 (early exit; remaining circles skipped).
  - `in_range`=1 and k<K-1: k←k+1, P unchanged.
  - `in_range`=1 and k=K-1: count+1, sum_x+=xP, sum_y+=yP (sign-extended), advance point, k=0.
- Advance point: if xP≠x_hi then xP+1; else xP=x_lo and, if yP≠y_hi, yP+1. If P was (x_hi,y_hi), go to DONE instead; the accumulation for that final point still applies.
- DONE: assert `done` for one cycle, set `found`, return to IDLE. Results hold until the next accepted `start`.
- Comparisons against bounds are signed, with equality-based wrap, so no counter overflows for any legal bounds.
- `count` and sum widths are sized for the full (N+2)-bit grid and cannot overflow.
- `xJ`/`yJ`/`rJ` always show slice k of the latched buses; input changes while `busy` have no effect.
- `start` while `busy` or in DONE is ignored.

## Timing
- Reset values: state IDLE; all outputs 0; internal k and latched registers 0.
- `start` sampled at edge E0. `busy`=1 and the first (P,k) is presented from E0 to E1. The first evaluation is sampled at E1.
- One evaluation per cycle. Total evaluations = P_rej·(1 + index of first failing circle) + P_acc·K.
- The edge after the last evaluation sets `done`=1 and `busy`=0 in the same cycle. Results are valid in that cycle.
- Empty grid: `done` one cycle after the `start` edge with count 0.
- `in_range` is combinational from the registered outputs; the whole path must close in one cycle.
- `rst` asserted mid-scan: immediate return to IDLE and all outputs 0; no `done` is issued.

## Test plan
- N=8, K=3; all circles (0,0,r=1); grid −2..2 × −2..2 → count 5, sum_x 0, sum_y 0, found 1; 35 evaluation cycles, `done` 36 cycles after `start`.
- Grid 0..3 × 0..1; all circles (0,0,r=100) → count 8, sum_x 12, sum_y 4; 24 evaluation cycles.
- Circles (−50,0,5), (50,0,5), (0,0,5); grid −10..10 × −10..10 → count 0, found 0; every point rejected at k=0 or k=1.
- Single-point grid x=y=10; circles all (10,10,r=0) → count 1, sum_x 10, sum_y 10; exactly 3 evaluations. Empty grid x_lo=3, x_hi=2 → `done` one cycle after `start`, count 0.
- `start` re-pulsed mid-scan → ignored, results unchanged. `rst` pulsed mid-scan → `busy`/`done`/`count`/sums 0 immediately, no `done`. A subsequent `start` completes normally.
- Change `xJ_all` and bounds while `busy` → results equal those of the values latched at `start`.
